// File: rtl/mux_pkg.sv
// Shared definitions for the arbitrated mux: arbitration mode codes and a
// ceiling-log2 helper usable in parameter defaults.
package mux_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  typedef enum logic {
    LK_OPEN,
    LK_HELD
  } lock_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority arbiter with optional packet lock.
// Macro ARB_MUX_LOCK_EN adds advance_last and holds the grant until the last beat.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned RR     = ARB_RR,
  parameter int unsigned SEL_W  = (clog2(NUM_IN) > 0) ? clog2(NUM_IN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] req,
  input  logic              advance,
  input  logic [SEL_W-1:0]  advance_idx,
`ifdef ARB_MUX_LOCK_EN
  input  logic              advance_last,
`endif
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  logic [SEL_W-1:0]    ptr;
  logic [SEL_W-1:0]    ptr_next;
  logic [SEL_W-1:0]    base;
  logic [NUM_IN-1:0]   elig;
  logic [2*NUM_IN-1:0] dbl;
  logic [NUM_IN-1:0]   rot;
  logic                found;
  logic                ptr_step;
  int unsigned         sum;

`ifdef ARB_MUX_LOCK_EN
  lock_state_t      lock_state;
  lock_state_t      lock_state_next;
  logic [SEL_W-1:0] lock_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_state <= LK_OPEN;
      lock_idx   <= '0;
    end else begin
      lock_state <= lock_state_next;
      if (advance) lock_idx <= advance_idx;
    end
  end

  always_comb begin
    lock_state_next = lock_state;
    if (advance) lock_state_next = advance_last ? LK_OPEN : LK_HELD;
  end

  always_comb begin
    elig = req;
    if (lock_state == LK_HELD) begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        elig[i] = req[i] && (SEL_W'(i) == lock_idx);
      end
    end
  end

  assign ptr_step = advance && advance_last;
`else
  assign elig     = req;
  assign ptr_step = advance;
`endif

  // Rotate requests so the search always starts at bit 0, then map back.
  assign base = (RR == ARB_RR) ? ptr : '0;
  assign dbl  = {elig, elig} >> base;
  assign rot  = dbl[NUM_IN-1:0];

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    sum       = 0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = 32'(base) + k;
        if (sum >= NUM_IN) sum = sum - NUM_IN;
        grant_idx = SEL_W'(sum);
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      grant[i] = found && (grant_idx == SEL_W'(i));
    end
  end

  always_comb begin
    ptr_next = ptr;
    if ((RR == ARB_RR) && ptr_step) begin
      ptr_next = (32'(advance_idx) == NUM_IN - 1) ? '0 : advance_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr_next;
  end

endmodule

// File: rtl/arb_mux.sv
// N-input arbitrated mux with registered valid/ready output stage.
// Macro ARB_MUX_LOCK_EN adds in_last/out_last and packet-locked arbitration.
module arb_mux
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned SEL_W  = (clog2(NUM_IN) > 0) ? clog2(NUM_IN) : 1,
  parameter int unsigned RR     = ARB_RR
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
`ifdef ARB_MUX_LOCK_EN
  ,
  input  logic [NUM_IN-1:0]       in_last,
  output logic                    out_last
`endif
);

  logic              accept;
  logic              transfer;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  sel_data;
  logic              sel_last;

  assign accept   = !out_valid || out_ready;
  assign in_ready = (accept && !reset) ? grant : '0;
  assign transfer = |in_ready;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
`ifdef ARB_MUX_LOCK_EN
      sel_last = sel_last | (in_last[i] & grant[i]);
`endif
    end
  end

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .RR     (RR),
    .SEL_W  (SEL_W)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .req          (in_valid),
    .advance      (transfer),
    .advance_idx  (grant_idx),
`ifdef ARB_MUX_LOCK_EN
    .advance_last (sel_last),
`endif
    .grant        (grant),
    .grant_idx    (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (accept) begin
      out_valid <= transfer;
      if (transfer) begin
        out_data <= sel_data;
        out_src  <= grant_idx;
      end
    end
  end

`ifdef ARB_MUX_LOCK_EN
  always_ff @(posedge clk) begin
    if (reset)                    out_last <= 1'b0;
    else if (accept && transfer)  out_last <= sel_last;
  end
`endif

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: per-cycle model comparison plus directed literals.
// Exercises the ARB_MUX_LOCK_EN variant when that macro is defined.
module tb_arb_mux;
  import mux_pkg::*;

`ifdef ARB_MUX_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  dv, dl;
  logic [15:0] dd;
  logic        rdy;
  logic [3:0]  cv, cl;
  logic [31:0] cd;
  logic        crdy;

  logic [1:0] a_rdy, b_rdy;
  logic [7:0] a_od, b_od, c_od;
  logic       a_ov, b_ov, c_ov;
  logic       a_os, b_os;
  logic [1:0] c_os;
  logic [3:0] c_rdy;
  logic       a_ol, b_ol, c_ol;

  int n_tests = 0;
  int n_fail  = 0;

  arb_mux #(.WIDTH(8), .NUM_IN(2), .RR(ARB_RR)) u_a (
    .clk(clk), .reset(reset), .in_data(dd), .in_valid(dv), .in_ready(a_rdy),
    .out_data(a_od), .out_valid(a_ov), .out_ready(rdy), .out_src(a_os)
`ifdef ARB_MUX_LOCK_EN
    , .in_last(dl), .out_last(a_ol)
`endif
  );

  arb_mux #(.WIDTH(8), .NUM_IN(2), .RR(ARB_FIXED)) u_b (
    .clk(clk), .reset(reset), .in_data(dd), .in_valid(dv), .in_ready(b_rdy),
    .out_data(b_od), .out_valid(b_ov), .out_ready(rdy), .out_src(b_os)
`ifdef ARB_MUX_LOCK_EN
    , .in_last(dl), .out_last(b_ol)
`endif
  );

  arb_mux #(.WIDTH(8), .NUM_IN(4), .RR(ARB_RR)) u_c (
    .clk(clk), .reset(reset), .in_data(cd), .in_valid(cv), .in_ready(c_rdy),
    .out_data(c_od), .out_valid(c_ov), .out_ready(crdy), .out_src(c_os)
`ifdef ARB_MUX_LOCK_EN
    , .in_last(cl), .out_last(c_ol)
`endif
  );

  typedef struct {
    int ptr;
    bit ov;
    int od;
    int os;
    bit ol;
    bit lk;
    int li;
  } mst_t;

  mst_t ma = '{default: 0};
  mst_t mb = '{default: 0};
  mst_t mc = '{default: 0};

  // Channel that wins this cycle, or -1 when nobody is eligible.
  function automatic int m_grant(mst_t s, int n, bit rr, logic [3:0] v);
    if (LOCK && s.lk) return v[s.li] ? s.li : -1;
    for (int k = 0; k < n; k++) begin
      int j = rr ? (s.ptr + k) % n : k;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ready(mst_t s, int n, bit rr, logic [3:0] v,
                                         bit ordy, bit rst);
    int g;
    if (rst || (s.ov && !ordy)) return 4'b0;
    g = m_grant(s, n, rr, v);
    return (g < 0) ? 4'b0 : (4'b1 << g);
  endfunction

  function automatic mst_t m_next(mst_t s, int n, bit rr, logic [3:0] v, logic [31:0] d,
                                  logic [3:0] l, bit ordy, bit rst);
    mst_t r;
    int   g;
    r = s;
    if (rst) begin
      r = '{default: 0};
      return r;
    end
    if (s.ov && !ordy) return r;
    g    = m_grant(s, n, rr, v);
    r.ov = (g >= 0);
    if (g >= 0) begin
      r.od = int'(d[g*8 +: 8]);
      r.os = g;
      if (LOCK) begin
        r.ol = l[g];
        r.lk = !l[g];
        r.li = g;
      end
      if (rr && (!LOCK || l[g])) r.ptr = (g + 1) % n;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a_ov",  32'(a_ov),  32'(ma.ov));
    chk("a_od",  32'(a_od),  32'(ma.od));
    chk("a_os",  32'(a_os),  32'(ma.os));
    chk("a_rdy", 32'(a_rdy), 32'(m_ready(ma, 2, 1'b1, {2'b0, dv}, rdy, reset)));
    chk("b_ov",  32'(b_ov),  32'(mb.ov));
    chk("b_od",  32'(b_od),  32'(mb.od));
    chk("b_os",  32'(b_os),  32'(mb.os));
    chk("b_rdy", 32'(b_rdy), 32'(m_ready(mb, 2, 1'b0, {2'b0, dv}, rdy, reset)));
    chk("c_ov",  32'(c_ov),  32'(mc.ov));
    chk("c_od",  32'(c_od),  32'(mc.od));
    chk("c_os",  32'(c_os),  32'(mc.os));
    chk("c_rdy", 32'(c_rdy), 32'(m_ready(mc, 4, 1'b1, cv, crdy, reset)));
`ifdef ARB_MUX_LOCK_EN
    chk("a_ol", 32'(a_ol), 32'(ma.ol));
    chk("b_ol", 32'(b_ol), 32'(mb.ol));
    chk("c_ol", 32'(c_ol), 32'(mc.ol));
`endif
    ma = m_next(ma, 2, 1'b1, {2'b0, dv}, {16'b0, dd}, {2'b0, dl}, rdy, reset);
    mb = m_next(mb, 2, 1'b0, {2'b0, dv}, {16'b0, dd}, {2'b0, dl}, rdy, reset);
    mc = m_next(mc, 4, 1'b1, cv, cd, cl, crdy, reset);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; dv = 2'b11; dd = 16'h2211; rdy = 1'b1; dl = '1;
    cv = '0; cd = 32'h44332211; crdy = 1'b1; cl = '1;
    tick; tick;
    chk("rst_ov",  32'(a_ov),  32'd0);
    chk("rst_od",  32'(a_od),  32'd0);
    chk("rst_rdy", 32'(a_rdy), 32'd0);

    reset = 1'b0; dv = 2'b01; dd = 16'h00A5;
    tick;
    chk("beat_ov", 32'(a_ov), 32'd1);
    chk("beat_od", 32'(a_od), 32'hA5);
    chk("beat_os", 32'(a_os), 32'd0);
    dv = 2'b00;
    tick;
    chk("idle_ov", 32'(a_ov), 32'd0);

    reset = 1'b1;
    tick;
    reset = 1'b0; dv = 2'b11; dd = 16'h2211;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("rr_od", 32'(a_od), (k % 2 == 1) ? 32'h22 : 32'h11);
      chk("rr_os", 32'(a_os), 32'(k % 2));
      chk("fp_od", 32'(b_od), 32'h11);
    end

    dv = 2'b01; dd = 16'h0033;
    tick;
    chk("bp_load", 32'(a_od), 32'h33);
    rdy = 1'b0; dd = 16'h0044;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("bp_od",  32'(a_od),  32'h33);
      chk("bp_rdy", 32'(a_rdy), 32'd0);
    end
    rdy = 1'b1;
    #1;
    chk("rel_rdy", 32'(a_rdy), 32'b01);
    tick;
    chk("rel_od", 32'(a_od), 32'h44);
    chk("rel_ov", 32'(a_ov), 32'd1);
    dv = 2'b00;
    tick;

    cv = 4'b0010;
    tick;
    chk("c_pre_os", 32'(c_os), 32'd1);
    cv = 4'b1000;
    tick;
    chk("c_wrap_os", 32'(c_os), 32'd3);
    chk("c_wrap_od", 32'(c_od), 32'h44);
    cv = 4'b0001;
    tick;
    chk("c_zero_os", 32'(c_os), 32'd0);
    chk("c_zero_od", 32'(c_od), 32'h11);
    cv = 4'b1111;
    tick;
    chk("c_ptr1_os", 32'(c_os), 32'd1);
    cv = 4'b0000;
    tick;

`ifdef ARB_MUX_LOCK_EN
    reset = 1'b1;
    tick;
    reset = 1'b0; dv = 2'b11; dd = 16'h2211;
    for (int k = 0; k < 4; k++) begin
      dl = {1'b1, (k == 2)};
      tick;
      chk("lock_os", 32'(a_os), 32'(k == 3));
      if (k < 3) chk("lock_last", 32'(a_ol), 32'(k == 2));
    end
    dl = '1; dv = 2'b00;
    tick;
`endif

    for (int k = 0; k < 80; k++) begin
      dv   = 2'($urandom);
      dd   = 16'($urandom);
      rdy  = ($urandom_range(0, 3) != 0);
      cv   = 4'($urandom);
      cd   = $urandom;
      crdy = ($urandom_range(0, 3) != 0);
      dl   = LOCK ? 2'($urandom) : 2'b11;
      cl   = LOCK ? 4'($urandom) : 4'b1111;
      tick;
    end
    dv = '0; cv = '0;
    tick; tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
